onchip_mem_copy_master: RTL and testbench
=========================================

Name: onchip_mem_copy_master

Overview:
- Avalon-MM master that copies a block of 32-bit words from one word address range to another.
- Drives the on-chip memory slave (single-port RAM, registered address, unregistered output) or any slave with fixed read latency and waitrequest.
- Used for boot-time relocation and buffer moves without the Nios II core.
- A control port starts a copy; a one-cycle pulse reports completion.

Parameters:
- ADDR_W, 14, word-address width of the master port.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, cycles from read acceptance to readdata sample; legal range 1..4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  copy request, sampled only in IDLE.
- src_addr  in  ADDR_W  first source word address.
- dst_addr  in  ADDR_W  first destination word address.
- length  in  ADDR_W+1  number of words to copy (0 allowed).
- busy  out  1  high from the cycle after start is accepted until the cycle after done.
- done  out  1  one-cycle completion pulse.
- m_address  out  ADDR_W  word address.
- m_chipselect  out  1  asserted with m_read or m_write.
- m_read  out  1  read request.
- m_write  out  1  write request.
- m_byteenable  out  DATA_W/8  all ones while m_write is high, else 0.
- m_writedata  out  DATA_W  captured read word.
- m_readdata  in  DATA_W  slave read data.
- m_waitrequest  in  1  slave stall; tie to 0 for on-chip RAM.

Behaviour:
- Reset: busy=0, done=0, m_chipselect=0, m_read=0, m_write=0, m_byteenable=0, m_address=0, m_writedata=0; state IDLE; word index 0. Reset mid-copy aborts on the next edge; no done pulse; no write remains pending.
- States: IDLE, READ, RWAIT, WRITE, DONE.
- IDLE:
  - On start=1, latch src_addr, dst_addr and length; clear the index.
  - length=0 goes to DONE; otherwise READ.
- READ:
  - m_chipselect=1, m_read=1, m_address=src+idx.
  - Signals hold stable while m_waitrequest=1.
  - The read is accepted on the edge where m_waitrequest=0; go to RWAIT.
- RWAIT:
  - m_read=0, m_chipselect=0.
  - Stay READ_LATENCY-1 additional cycles.
  - m_readdata is sampled into the data register on the edge exactly READ_LATENCY cycles after the acceptance edge; go to WRITE.
- WRITE:
  - m_chipselect=1, m_write=1, m_address=dst+idx, m_writedata=captured word, m_byteenable=all ones.
  - Hold while m_waitrequest=1.
  - On acceptance, idx increments; if idx+1==length go to DONE, else READ.
- DONE: done=1 for exactly one cycle, then IDLE; busy drops in the same cycle as the return to IDLE.
- Throughput with waitrequest=0 and READ_LATENCY=L: 2+L cycles per word. done is asserted in cycle N*(2+L)+1 after the start edge.
- Address arithmetic is modulo 2^ADDR_W; src+idx and dst+idx wrap silently.
- start while busy is ignored; no queueing.
- Copies run strictly forward. Overlapping ranges with dst>src propagate source data; this is defined behaviour, not an error.
- m_read and m_write are never high in the same cycle.

Optional Feature:
- Macro: COPY_MASTER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum [31:0].
  - Cleared when start is accepted.
  - On each write acceptance, checksum <= checksum + m_writedata (mod 2^32).
  - Value is stable from done until the next accepted start; reset clears it to 0.
- Undefined: the port and the adder are absent; all other behaviour is identical.

Test Plan:
- Single word:
  - Stimulus: mem[0x010]=0xDEADBEEF; src=0x010, dst=0x020, length=1, L=1, waitrequest=0.
  - Response: read at 0x010, write 0xDEADBEEF to 0x020; done in cycle 4 after start; busy high cycles 1-4.
- Block copy:
  - Stimulus: 16 words 0x00000000..0x0000000F at 0x100; copy to 0x200.
  - Response: exact match; 16 writes; done at cycle 49; checksum=0x00000078 when the macro is defined.
- Zero length:
  - Stimulus: length=0.
  - Response: no m_read or m_write; done=1 in cycle 1; busy=0 afterwards.
- Waitrequest stall:
  - Stimulus: m_waitrequest=1 for 3 cycles on the first read and 2 cycles on the first write.
  - Response: address and control stable throughout the stalls; data correct; done delayed by exactly 5 cycles.
- Wrap and latency:
  - Stimulus: src=0x3FFE, length=4, READ_LATENCY=3.
  - Response: reads at 0x3FFE, 0x3FFF, 0x0000, 0x0001; 5 cycles per word.
- Reset and ignored start:
  - Stimulus: reset asserted in WRITE of word 2 of 8; separately, start pulsed while busy.
  - Response: on reset, all outputs 0 on the next edge and no done pulse. The mid-copy start is ignored and the latched addresses are unchanged.

Source files
------------

// File: rtl/onchip_mem_copy_master.sv
// onchip_mem_copy_master
// Avalon-MM master that copies a block of words from one word-address range
// to another, one read followed by one write per word.
// Optional build macro: COPY_MASTER_CHECKSUM_EN adds a 32-bit running sum of
// all written words on output port checksum.
//
// Handshake: a request (m_read or m_write, with m_chipselect) is accepted on
// the rising edge where m_waitrequest is low; while m_waitrequest is high the
// address, data and control outputs are held unchanged.
// The FSM state is visible for debug as state_q (type copy_state_t).
module onchip_mem_copy_master #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_chipselect,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_waitrequest
`ifdef COPY_MASTER_CHECKSUM_EN
  ,
  output logic [31:0]         checksum
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    RWAIT = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } copy_state_t;

  // Last value of the latency counter: readdata is sampled when it is reached.
  localparam logic [1:0]    LAT_LAST = 2'(READ_LATENCY - 1);
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

  copy_state_t       state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [ADDR_W:0]   len_q, idx_q, idx_nxt;
  logic [1:0]        lat_q;
  logic [DATA_W-1:0] data_q;
  logic              rd_accept, wr_accept, lat_hit;

  assign idx_nxt   = idx_q + IDX_ONE;
  assign rd_accept = (state_q == READ)  && !m_waitrequest;
  assign wr_accept = (state_q == WRITE) && !m_waitrequest;
  assign lat_hit   = (state_q == RWAIT) && (lat_q == LAT_LAST);

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign m_writedata = data_q;

  // State register plus latched job parameters, word index and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      lat_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        len_q <= length;
        idx_q <= '0;
      end
      if (rd_accept) lat_q <= '0;
      if (state_q == RWAIT) begin
        if (lat_hit) begin
          data_q <= m_readdata;
          lat_q  <= '0;
        end else begin
          lat_q <= lat_q + 2'd1;
        end
      end
      if (wr_accept) idx_q <= idx_nxt;
    end
  end

  // Next-state selection and bus request outputs decoded from the state.
  always_comb begin
    state_d      = state_q;
    m_chipselect = 1'b0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_address    = '0;
    m_byteenable = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (length == '0) ? DONE : READ;
      end
      READ: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_address    = src_q + idx_q[ADDR_W-1:0];
        if (!m_waitrequest) state_d = RWAIT;
      end
      RWAIT: begin
        if (lat_hit) state_d = WRITE;
      end
      WRITE: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_address    = dst_q + idx_q[ADDR_W-1:0];
        m_byteenable = '1;
        if (!m_waitrequest) state_d = (idx_nxt == len_q) ? DONE : READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef COPY_MASTER_CHECKSUM_EN
  // Running sum of every accepted write word; cleared when a copy starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (state_q == IDLE && start) begin
      checksum <= '0;
    end else if (wr_accept) begin
      checksum <= checksum + 32'(data_q);
    end
  end
`endif

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Directed bench for onchip_mem_copy_master. Two instances: READ_LATENCY=1
// and READ_LATENCY=3, sharing one word memory model. Honours the optional
// COPY_MASTER_CHECKSUM_EN macro for the checksum port.
module tb_onchip_mem_copy_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus ----------------
  logic        start = 1'b0;
  logic        sel3  = 1'b0;
  logic [13:0] src_addr = '0, dst_addr = '0;
  logic [14:0] length = '0;
  logic        m_waitrequest = 1'b0;

  logic        busy1, done1, cs1, rd1, wr1, busy3, done3, cs3, rd3, wr3;
  logic [13:0] a1, a3;
  logic [3:0]  be1, be3;
  logic [31:0] wd1, wd3, rdata1, rdata3;
`ifdef COPY_MASTER_CHECKSUM_EN
  logic [31:0] sum1, sum3;
`endif

  onchip_mem_copy_master #(.ADDR_W(14), .DATA_W(32), .READ_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset), .start(start && !sel3),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy1), .done(done1), .m_address(a1), .m_chipselect(cs1),
    .m_read(rd1), .m_write(wr1), .m_byteenable(be1), .m_writedata(wd1),
    .m_readdata(rdata1), .m_waitrequest(m_waitrequest)
`ifdef COPY_MASTER_CHECKSUM_EN
    , .checksum(sum1)
`endif
  );

  onchip_mem_copy_master #(.ADDR_W(14), .DATA_W(32), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start && sel3),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy3), .done(done3), .m_address(a3), .m_chipselect(cs3),
    .m_read(rd3), .m_write(wr3), .m_byteenable(be3), .m_writedata(wd3),
    .m_readdata(rdata3), .m_waitrequest(m_waitrequest)
`ifdef COPY_MASTER_CHECKSUM_EN
    , .checksum(sum3)
`endif
  );

  // Observed instance
  logic        o_busy, o_done, o_cs, o_rd, o_wr;
  logic [13:0] o_addr;
  logic [3:0]  o_be;
  logic [31:0] o_wd;
  assign o_busy = sel3 ? busy3 : busy1;
  assign o_done = sel3 ? done3 : done1;
  assign o_cs   = sel3 ? cs3   : cs1;
  assign o_rd   = sel3 ? rd3   : rd1;
  assign o_wr   = sel3 ? wr3   : wr1;
  assign o_addr = sel3 ? a3    : a1;
  assign o_be   = sel3 ? be3   : be1;
  assign o_wd   = sel3 ? wd3   : wd1;
`ifdef COPY_MASTER_CHECKSUM_EN
  logic [31:0] o_sum;
  assign o_sum = sel3 ? sum3 : sum1;
`endif

  // ---------------- memory model ----------------
  // Registered address, unregistered data; the latency-3 path adds two stages.
  logic [31:0] mem [0:16383];
  logic [13:0] rd_addr1;
  logic [13:0] pipe3 [0:2];
  always @(posedge clk) begin
    rd_addr1 <= a1;
    pipe3[0] <= a3;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rdata1 = mem[rd_addr1];
  assign rdata3 = mem[pipe3[2]];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [13:0] rd_q[$];
  logic [13:0] wr_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] exp_q[$];
  bit excl_ok, busy_ok, stable_ok, be_ok;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Starts a copy at the current negedge, then plays the slave side cycle by
  // cycle. done_cyc = cycle index of done (1 = first cycle after start edge),
  // -1 on timeout, -2 when the run was cut by reset.
  task automatic run_copy(input logic [13:0] s, input logic [13:0] d, input logic [14:0] n,
                          input bit use3, input int rd_stall, input int wr_stall,
                          input bit ign_start, input int rst_at_wr, output int done_cyc);
    int rs, ws, cyc;
    bit prev_wait;
    logic [13:0] prev_addr;
    logic prev_rd, prev_wr;
    rd_q.delete(); wr_q.delete(); wd_q.delete();
    excl_ok = 1; busy_ok = 1; stable_ok = 1; be_ok = 1;
    done_cyc = -1; prev_wait = 0; prev_addr = '0; prev_rd = 0; prev_wr = 0;
    rs = rd_stall; ws = wr_stall;
    sel3 = use3; src_addr = s; dst_addr = d; length = n;
    start = 1'b1; m_waitrequest = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 300) begin
      if (o_rd && o_wr) excl_ok = 0;
      if (!o_busy) busy_ok = 0;
      if (o_cs !== (o_rd || o_wr)) excl_ok = 0;
      if (o_be !== (o_wr ? 4'hF : 4'h0)) be_ok = 0;
      if (prev_wait && (o_addr !== prev_addr || o_rd !== prev_rd || o_wr !== prev_wr)) stable_ok = 0;
      if (o_rd && rs > 0) begin m_waitrequest = 1'b1; rs--; end
      else if (o_wr && ws > 0) begin m_waitrequest = 1'b1; ws--; end
      else m_waitrequest = 1'b0;
      if (o_rd && !m_waitrequest) rd_q.push_back(o_addr);
      if (o_wr && !m_waitrequest) begin
        wr_q.push_back(o_addr);
        wd_q.push_back(o_wd);
        mem[o_addr] = o_wd;
      end
      if (ign_start && cyc == 2) begin
        start = 1'b1; src_addr = 14'h3333; dst_addr = 14'h3444; length = 15'd9;
      end else begin
        start = 1'b0;
      end
      if (rst_at_wr >= 0 && o_wr && wr_q.size() == rst_at_wr + 1) begin
        reset = 1'b1;
        done_cyc = -2;
        break;
      end
      if (o_done) begin
        done_cyc = cyc;
        break;
      end
      prev_wait = m_waitrequest; prev_addr = o_addr; prev_rd = o_rd; prev_wr = o_wr;
      @(negedge clk);
      cyc++;
    end
    m_waitrequest = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_after_done(input string tag);
    @(negedge clk);
    chk({tag, "_done_low"}, 64'(o_done), 64'd0);
    chk({tag, "_busy_low"}, 64'(o_busy), 64'd0);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwrites"}, 64'(wd_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) chk($sformatf("%s_wdata%0d", tag, i), 64'(wd_q[i]), 64'(exp_q[i]));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int dc;
    bit saw_done;
    logic [13:0] exp_rd [4];

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs1", {busy1, done1, cs1, rd1, wr1, be1, a1, wd1}, 64'd0);
    chk("reset_outputs3", {busy3, done3, cs3, rd3, wr3, be3, a3, wd3}, 64'd0);
`ifdef COPY_MASTER_CHECKSUM_EN
    chk("reset_checksum", 64'(sum1), 64'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Single word
    mem[14'h010] = 32'hDEADBEEF;
    run_copy(14'h010, 14'h020, 15'd1, 0, 0, 0, 0, -1, dc);
    chk("single_done_cycle", 64'(dc), 64'd4);
    chk("single_rd_addr", 64'(rd_q[0]), 64'h010);
    chk("single_wr_addr", 64'(wr_q[0]), 64'h020);
    chk("single_mem", 64'(mem[14'h020]), 64'hDEADBEEF);
    chk("single_busy", 64'(busy_ok), 64'd1);
    chk("single_excl", 64'(excl_ok), 64'd1);
    chk("single_be", 64'(be_ok), 64'd1);
`ifdef COPY_MASTER_CHECKSUM_EN
    chk("single_checksum", 64'(o_sum), 64'hDEADBEEF);
`endif
    check_after_done("single");

    // Block copy of 16 words
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      mem[14'h100 + 14'(i)] = 32'(i);
      exp_q.push_back(32'(i));
    end
    run_copy(14'h100, 14'h200, 15'd16, 0, 0, 0, 0, -1, dc);
    chk("block_done_cycle", 64'(dc), 64'd49);
    check_writes("block");
    for (int i = 0; i < 16; i++)
      chk($sformatf("block_mem%0d", i), 64'(mem[14'h200 + 14'(i)]), 64'(i));
    chk("block_excl", 64'(excl_ok), 64'd1);
    chk("block_be", 64'(be_ok), 64'd1);
`ifdef COPY_MASTER_CHECKSUM_EN
    chk("block_checksum", 64'(o_sum), 64'h78);
`endif
    check_after_done("block");

    // Zero length
    run_copy(14'h100, 14'h300, 15'd0, 0, 0, 0, 0, -1, dc);
    chk("zero_done_cycle", 64'(dc), 64'd1);
    chk("zero_nreads", 64'(rd_q.size()), 64'd0);
    chk("zero_nwrites", 64'(wr_q.size()), 64'd0);
    check_after_done("zero");

    // Waitrequest stall: 3 cycles on first read, 2 on first write
    mem[14'h040] = 32'hA5A50001;
    mem[14'h041] = 32'h5A5A0002;
    exp_q.delete();
    exp_q.push_back(32'hA5A50001);
    exp_q.push_back(32'h5A5A0002);
    run_copy(14'h040, 14'h050, 15'd2, 0, 3, 2, 0, -1, dc);
    chk("stall_done_cycle", 64'(dc), 64'd12);
    chk("stall_stable", 64'(stable_ok), 64'd1);
    check_writes("stall");
    chk("stall_mem0", 64'(mem[14'h050]), 64'hA5A50001);
    chk("stall_mem1", 64'(mem[14'h051]), 64'h5A5A0002);
`ifdef COPY_MASTER_CHECKSUM_EN
    chk("stall_checksum", 64'(o_sum), 64'hFFFF0003);
`endif
    check_after_done("stall");

    // Address wrap with READ_LATENCY=3
    mem[14'h3FFE] = 32'h11111111;
    mem[14'h3FFF] = 32'h22222222;
    mem[14'h0000] = 32'h33333333;
    mem[14'h0001] = 32'h44444444;
    exp_rd[0] = 14'h3FFE; exp_rd[1] = 14'h3FFF; exp_rd[2] = 14'h0000; exp_rd[3] = 14'h0001;
    exp_q.delete();
    exp_q.push_back(32'h11111111); exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h33333333); exp_q.push_back(32'h44444444);
    run_copy(14'h3FFE, 14'h0800, 15'd4, 1, 0, 0, 0, -1, dc);
    chk("wrap_done_cycle", 64'(dc), 64'd21);
    chk("wrap_nreads", 64'(rd_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_rd_addr%0d", i), 64'(rd_q[i]), 64'(exp_rd[i]));
    check_writes("wrap");
    chk("wrap_excl", 64'(excl_ok), 64'd1);
`ifdef COPY_MASTER_CHECKSUM_EN
    chk("wrap_checksum", 64'(o_sum), 64'hAAAAAAAA);
`endif
    check_after_done("wrap");

    // Start pulsed while busy is ignored
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      mem[14'h060 + 14'(i)] = 32'h1000 + 32'(i);
      exp_q.push_back(32'h1000 + 32'(i));
    end
    run_copy(14'h060, 14'h070, 15'd4, 0, 0, 0, 1, -1, dc);
    chk("ignstart_done_cycle", 64'(dc), 64'd13);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ignstart_rd%0d", i), 64'(rd_q[i]), 64'(14'h060 + 14'(i)));
      chk($sformatf("ignstart_wr%0d", i), 64'(wr_q[i]), 64'(14'h070 + 14'(i)));
    end
    check_writes("ignstart");
    check_after_done("ignstart");

    // Reset in WRITE of word 2 of 8
    for (int i = 0; i < 8; i++) mem[14'h080 + 14'(i)] = 32'h2000 + 32'(i);
    run_copy(14'h080, 14'h090, 15'd8, 0, 0, 0, 0, 1, dc);
    chk("rst_cut", 64'(dc), 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    chk("rst_outputs", {busy1, done1, cs1, rd1, wr1, be1, a1, wd1}, 64'd0);
`ifdef COPY_MASTER_CHECKSUM_EN
    chk("rst_checksum", 64'(sum1), 64'd0);
`endif
    reset = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_done || o_busy || o_rd || o_wr) saw_done = 1;
    end
    chk("rst_quiet", 64'(saw_done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
